// File: rtl/mem_sram_pkg.sv
// Shared constants and controller state type for the mem_sram block.
// Also holds a helper that sizes the clear-sweep counter.
package mem_sram_pkg;

  localparam int DEF_A_WIDTH = 8;
  localparam int DEF_D_WIDTH = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // Counter must reach DEPTH itself, not just DEPTH-1, so it never wraps.
  function automatic int sweep_cnt_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/mem_sram_array.sv
// Storage array: one synchronous write port, one registered read port with clear.
// Macro MEM_SRAM_WRITE_THROUGH_EN selects write-first bypass; default is read-first.
module mem_sram_array #(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 256
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [A_WIDTH-1:0] waddr_i,
  input  logic [D_WIDTH-1:0] wdata_i,
  input  logic               re_i,
  input  logic               rclr_i,
  input  logic [A_WIDTH-1:0] raddr_i,
  output logic [D_WIDTH-1:0] rdata_o
);

  logic [D_WIDTH-1:0] mem_q [DEPTH];
  logic [D_WIDTH-1:0] rdata_q;
  logic [D_WIDTH-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rclr_i) begin
      rdata_d = '0;
    end else if (re_i) begin
`ifdef MEM_SRAM_WRITE_THROUGH_EN
      if (we_i && (waddr_i == raddr_i)) begin
        rdata_d = wdata_i;
      end else begin
        rdata_d = mem_q[raddr_i];
      end
`else
      // Array read sees the pre-edge contents, so a same-edge write is not visible.
      rdata_d = mem_q[raddr_i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_sram.sv
// Single-port SRAM wrapper: clears every word after reset, then serves 1-cycle reads and writes.
// Optional macro MEM_SRAM_WRITE_THROUGH_EN makes same-address read/write return the new data.
module mem_sram
  import mem_sram_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int D_WIDTH = DEF_D_WIDTH,
  parameter int DEPTH   = (1 << A_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               nWE,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] data_in,
  output logic [D_WIDTH-1:0] data_out,
  output logic               init_done
);

  localparam int CW = sweep_cnt_width(DEPTH);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic               in_range;
  logic               arr_we;
  logic [A_WIDTH-1:0] arr_waddr;
  logic [D_WIDTH-1:0] arr_wdata;
  logic               arr_re;
  logic               arr_rclr;

  assign in_range = ((A_WIDTH+1)'(addr) < (A_WIDTH+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_waddr = addr;
    arr_wdata = data_in;
    arr_re    = 1'b0;
    arr_rclr  = 1'b1;
    case (state_q)
      ST_CLEAR: begin
        arr_we    = !rst;
        arr_waddr = A_WIDTH'(cnt_q);
        arr_wdata = '0;
        cnt_d     = cnt_q + CW'(1);
        if (cnt_q == CW'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        // Out-of-range accesses drop the write and read back zero.
        arr_we   = !rst && !nWE && in_range;
        arr_re   = 1'b1;
        arr_rclr = rst || !in_range;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  mem_sram_array #(
    .A_WIDTH (A_WIDTH),
    .D_WIDTH (D_WIDTH),
    .DEPTH   (DEPTH)
  ) u_array (
    .clk     (clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .rclr_i  (arr_rclr),
    .raddr_i (addr),
    .rdata_o (data_out)
  );

  assign init_done = (state_q == ST_READY);

endmodule

// File: tb/tb_mem_sram.sv
// Directed bench for mem_sram: default-depth and DEPTH=200 instances share one stimulus stream.
module tb_mem_sram;

`ifdef MEM_SRAM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nWE = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] din = '0;
  logic [31:0] dout1, dout2;
  logic        init1, init2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_sram u_dut (
    .clk(clk), .rst(rst), .nWE(nWE), .addr(addr), .data_in(din),
    .data_out(dout1), .init_done(init1)
  );

  mem_sram #(.DEPTH(200)) u_dut200 (
    .clk(clk), .rst(rst), .nWE(nWE), .addr(addr), .data_in(din),
    .data_out(dout2), .init_done(init2)
  );

  typedef struct {
    logic        nwe;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input logic nwe, input logic [7:0] a, input logic [31:0] d,
                              input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.nwe = nwe; v.addr = a; v.din = d; v.exp1 = e1; v.exp2 = e2;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reset for two cycles, then count edges until each instance reports init_done.
  task automatic do_init(input string tag);
    int c1, c2, bad1, bad2;
    rst = 1'b1; nWE = 1'b0; addr = 8'h10; din = 32'hFFFF_FFFF;
    step(); step();
    check({tag, "_rst_dout"}, dout1, 32'h0);
    check({tag, "_rst_init"}, {31'h0, init1}, 32'h0);
    check({tag, "_rst_init200"}, {31'h0, init2}, 32'h0);
    rst = 1'b0;
    c1 = 0; c2 = 0; bad1 = 0; bad2 = 0;
    for (int i = 1; i <= 400; i++) begin
      if (i >= 150) nWE = 1'b1;
      addr = 8'(i);
      step();
      if (!init1 && dout1 != 32'h0) bad1++;
      if (!init2 && dout2 != 32'h0) bad2++;
      if (init1 && c1 == 0) c1 = i;
      if (init2 && c2 == 0) c2 = i;
      if (c1 != 0 && c2 != 0) break;
    end
    nWE = 1'b1;
    check({tag, "_sweep_cycles"}, 32'(c1), 32'd256);
    check({tag, "_sweep_cycles200"}, 32'(c2), 32'd200);
    check({tag, "_sweep_dout_nonzero"}, 32'(bad1), 32'd0);
    check({tag, "_sweep_dout200_nonzero"}, 32'(bad2), 32'd0);
  endtask

  task automatic rd(input string name, input logic [7:0] a,
                    input logic [31:0] e1, input logic [31:0] e2);
    nWE = 1'b1; addr = a;
    step();
    check({name, "_d256"}, dout1, e1);
    check({name, "_d200"}, dout2, e2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] e1, e2;
    //             nWE   addr   data_in        exp d256       exp d200
    vecs[0]  = mk(1'b0, 8'h22, 32'h01234567, 32'h00000000, 32'h00000000);
    vecs[1]  = mk(1'b0, 8'h01, 32'h12345678, 32'h00000000, 32'h00000000);
    vecs[2]  = mk(1'b0, 8'h14, 32'h23456789, 32'h00000000, 32'h00000000);
    vecs[3]  = mk(1'b1, 8'h01, 32'h0,        32'h12345678, 32'h12345678);
    vecs[4]  = mk(1'b1, 8'h80, 32'h0,        32'h00000000, 32'h00000000);
    vecs[5]  = mk(1'b1, 8'h14, 32'h0,        32'h23456789, 32'h23456789);
    vecs[6]  = mk(1'b1, 8'h10, 32'h0,        32'h00000000, 32'h00000000);
    vecs[7]  = mk(1'b0, 8'h05, 32'h11111111, 32'h00000000, 32'h00000000);
    vecs[8]  = mk(1'b0, 8'h05, 32'hDEADBEEF, 32'h11111111, 32'h11111111);
    vecs[9]  = mk(1'b1, 8'h05, 32'h0,        32'hDEADBEEF, 32'hDEADBEEF);
    vecs[10] = mk(1'b0, 8'hFF, 32'hA5A5A5A5, 32'h00000000, 32'h00000000);
    vecs[11] = mk(1'b1, 8'hFF, 32'h0,        32'hA5A5A5A5, 32'h00000000);
    vecs[12] = mk(1'b0, 8'hC8, 32'hCAFEF00D, 32'h00000000, 32'h00000000);
    vecs[13] = mk(1'b1, 8'hC8, 32'h0,        32'hCAFEF00D, 32'h00000000);
    vecs[14] = mk(1'b1, 8'hC7, 32'h0,        32'h00000000, 32'h00000000);
    vecs[15] = mk(1'b1, 8'h00, 32'h0,        32'h00000000, 32'h00000000);
    vecs[16] = mk(1'b1, 8'h22, 32'h0,        32'h01234567, 32'h01234567);

    do_init("init");

    for (int i = 0; i < 17; i++) begin
      nWE = vecs[i].nwe; addr = vecs[i].addr; din = vecs[i].din;
      step();
      e1 = vecs[i].exp1;
      e2 = vecs[i].exp2;
      if (WT && !vecs[i].nwe) begin
        e1 = vecs[i].din;
        if (vecs[i].addr < 8'd200) e2 = vecs[i].din;
      end
      check($sformatf("vec%0d_d256", i), dout1, e1);
      check($sformatf("vec%0d_d200", i), dout2, e2);
    end

    // data_out must hold between edges even when addr changes.
    nWE = 1'b1; addr = 8'h01;
    #3;
    check("hold_between_edges", dout1, 32'h01234567);
    step();
    check("read_after_hold", dout1, 32'h12345678);

    // Reset in the middle of the sweep, then a full re-initialisation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) step();
    do_init("reinit");
    rd("reinit_rd22", 8'h22, 32'h0, 32'h0);
    rd("reinit_rd05", 8'h05, 32'h0, 32'h0);
    rd("reinit_rdFF", 8'hFF, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
